// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave receive path.
package spi_pkg;

  localparam int SpiByteW      = 8;
  localparam int SpiSyncStages = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_END  = 2'd2
  } spi_slave_state_e;

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous show-ahead FIFO; a pop and a push may happen in the same cycle when full.
module spi_rx_fifo #(
  parameter int Depth = 4,
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  output logic [Width-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AddrW = $clog2(Depth);
  localparam logic [AddrW:0] DepthC = (AddrW + 1)'(Depth);
  localparam logic [AddrW:0] CountOne = (AddrW + 1)'(1);
  localparam logic [AddrW-1:0] PtrOne = AddrW'(1);

  logic [Width-1:0] mem [Depth];
  logic [AddrW-1:0] wr_ptr;
  logic [AddrW-1:0] rd_ptr;
  logic [AddrW:0]   count;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == DepthC);
  assign do_rd = rd_en && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_wr = wr_en && (!full || do_rd);

  // Head is forced to zero when empty so the output is defined out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PtrOne;
      if (do_rd) rd_ptr <= rd_ptr + PtrOne;
      case ({do_wr, do_rd})
        2'b10:   count <= count + CountOne;
        2'b01:   count <= count - CountOne;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: synchronizes SCLK/MOSI/CS into clk_i, deserializes MSB-first
// bytes and queues them in a show-ahead FIFO. Handshake: a byte leaves the FIFO on
// any rising clk_i edge where rx_valid_o && rx_ready_i; rx_data_o holds until then.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int FifoDepth = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                spi_slave_clk_i,
  input  logic                spi_slave_mosi_i,
  input  logic                spi_slave_cs_i,
  output logic [SpiByteW-1:0] rx_data_o,
  output logic                rx_valid_o,
  input  logic                rx_ready_i,
  output logic                frame_done_o,
  output logic                frame_err_o,
  output logic                overflow_o,
  output logic                busy_o,
  output spi_slave_state_e    state_o
);

  localparam logic ClkIdle    = (CPOL != 0);
  localparam logic SampleRise = (CPOL == CPHA);
  localparam int   CntW       = $clog2(SpiByteW);
  localparam logic [CntW-1:0] LastBit = CntW'(SpiByteW - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [1:0]      WarmDone = 2'(SpiSyncStages + 1);

  logic [SpiSyncStages-1:0] sclk_sync;
  logic [SpiSyncStages-1:0] cs_sync;
  logic [SpiSyncStages-1:0] mosi_sync;
  logic                     sclk_hist;
  logic                     cs_hist;
  logic                     sclk_s;
  logic                     cs_s;
  logic                     mosi_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync <= {SpiSyncStages{ClkIdle}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_hist <= ClkIdle;
      cs_hist   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SpiSyncStages-2:0], spi_slave_clk_i};
      cs_sync   <= {cs_sync[SpiSyncStages-2:0], spi_slave_cs_i};
      mosi_sync <= {mosi_sync[SpiSyncStages-2:0], spi_slave_mosi_i};
      sclk_hist <= sclk_s;
      cs_hist   <= cs_s;
    end
  end

  assign sclk_s = sclk_sync[SpiSyncStages-1];
  assign cs_s   = cs_sync[SpiSyncStages-1];
  assign mosi_s = mosi_sync[SpiSyncStages-1];

  logic sample_edge;
  logic cs_fall;
  logic cs_rise;

  assign sample_edge = SampleRise ? (sclk_s && !sclk_hist) : (!sclk_s && sclk_hist);
  assign cs_fall     = cs_hist && !cs_s;
  assign cs_rise     = !cs_hist && cs_s;

  // The CS pipeline holds reset values right after reset, so a frame may only start
  // once a genuinely sampled CS-high has been seen; this rejects mid-frame releases.
  logic [1:0] warm_cnt;
  logic       armed;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      warm_cnt <= '0;
      armed    <= 1'b0;
    end else begin
      if (warm_cnt != WarmDone) warm_cnt <= warm_cnt + 2'd1;
      if (warm_cnt == WarmDone && cs_s) armed <= 1'b1;
    end
  end

  spi_slave_state_e state;
  spi_slave_state_e state_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (armed && cs_fall) state_next = ST_RECV;
      ST_RECV: if (cs_rise) state_next = ST_END;
      ST_END:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  logic [SpiByteW-1:0] shift_q;
  logic [CntW-1:0]     bit_cnt;
  logic                sample_act;
  logic                byte_done;
  logic [SpiByteW-1:0] byte_next;

  // CS rising wins over a coincident sample edge; that bit belongs to a dead frame.
  assign sample_act = (state == ST_RECV) && !cs_rise && sample_edge;
  assign byte_done  = sample_act && (bit_cnt == LastBit);
  assign byte_next  = {shift_q[SpiByteW-2:0], mosi_s};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (state == ST_IDLE && state_next == ST_RECV) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (sample_act) begin
      shift_q <= byte_next;
      bit_cnt <= bit_cnt + CntOne;
    end
  end

  logic fifo_full;
  logic fifo_empty;
  logic pop;

  assign pop = rx_valid_o && rx_ready_i;

  spi_rx_fifo #(
    .Depth(FifoDepth),
    .Width(SpiByteW)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .wr_en  (byte_done),
    .wr_data(byte_next),
    .rd_en  (rx_ready_i),
    .rd_data(rx_data_o),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) overflow_o <= 1'b0;
    else         overflow_o <= byte_done && fifo_full && !pop;
  end

  assign rx_valid_o   = !fifo_empty;
  assign frame_done_o = (state == ST_END);
  assign frame_err_o  = (state == ST_END) && (bit_cnt != '0);
  assign busy_o       = (state == ST_RECV);
  assign state_o      = state;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: one instance per CPOL/CPHA mode, driven by an SPI master model.
module tb_spi_slave_rx;

  localparam int Depth = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sclk;
  logic [3:0] cs;
  logic       mosi;
  logic       ready;
  logic [7:0] rx_data [4];
  logic [3:0] rx_valid;
  logic [3:0] done;
  logic [3:0] err;
  logic [3:0] ovf;
  logic [3:0] busy;
  spi_pkg::spi_slave_state_e state_dbg [4];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic       tx_bits[$];
  int cur = 0;
  int done_cnt = 0, err_cnt = 0, lone_err = 0, ovf_cnt = 0, valid_cycles = 0;
  int exp_done = 0, exp_err = 0, exp_ovf = 0;

  always #10 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_rx #(
      .CPOL(g / 2),
      .CPHA(g % 2),
      .FifoDepth(Depth)
    ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .spi_slave_clk_i (sclk[g]),
      .spi_slave_mosi_i(mosi),
      .spi_slave_cs_i  (cs[g]),
      .rx_data_o       (rx_data[g]),
      .rx_valid_o      (rx_valid[g]),
      .rx_ready_i      (ready),
      .frame_done_o    (done[g]),
      .frame_err_o     (err[g]),
      .overflow_o      (ovf[g]),
      .busy_o          (busy[g]),
      .state_o         (state_dbg[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every pop from the active instance must match the model's next byte.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done[cur]) done_cnt++;
      if (err[cur]) err_cnt++;
      if (err[cur] && !done[cur]) lone_err++;
      if (ovf[cur]) ovf_cnt++;
      if (rx_valid[cur]) valid_cycles++;
      if (rx_valid[cur] && ready) begin
        if (exp_q.size() == 0) check("pop_unexpected", 32'(exp_q.size()), 32'd1);
        else check("pop_data", {24'h0, rx_data[cur]}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tx_bits.push_back(b[i]);
  endtask

  // Reference: whole bytes land in order unless the FIFO is full with no consumer.
  task automatic model_frame(input int nbits);
    for (int k = 0; k + 8 <= nbits; k += 8) begin
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b = {b[6:0], tx_bits[k + i]};
      if (ready || exp_q.size() < Depth) exp_q.push_back(b);
      else exp_ovf++;
    end
    exp_done++;
    if (nbits % 8 != 0) exp_err++;
  endtask

  task automatic shift_bits(input int m, input int n);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    for (int i = 0; i < n; i++) begin
      if (!cpha) begin
        mosi = tx_bits.pop_front();
        #40 sclk[m] = ~cpol;
        #40 sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi = tx_bits.pop_front();
        #40 sclk[m] = cpol;
        #40;
      end
    end
  endtask

  task automatic run_frame(input int m, input int nbits);
    model_frame(nbits);
    @(negedge clk);
    cs[m] = 1'b0;
    #100;
    check("busy_in_frame", 32'(busy[m]), 32'd1);
    shift_bits(m, nbits);
    #100 cs[m] = 1'b1;
    #400;
    check("busy_after_frame", 32'(busy[m]), 32'd0);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 ready = v;
  endtask

  task automatic drain();
    int n = 0;
    set_ready(1'b1);
    while ((exp_q.size() != 0 || rx_valid[cur]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < 200), 32'd1);
    set_ready(1'b0);
    @(negedge clk);
    check("drain_valid_low", 32'(rx_valid[cur]), 32'd0);
    check("drain_model_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_counts();
    check("frame_done_count", 32'(done_cnt), 32'(exp_done));
    check("frame_err_count", 32'(err_cnt), 32'(exp_err));
    check("frame_err_without_done", 32'(lone_err), 32'd0);
    check("overflow_count", 32'(ovf_cnt), 32'(exp_ovf));
  endtask

  initial begin
    rst_n = 1'b0;
    sclk  = 4'b1100;
    cs    = 4'hF;
    mosi  = 1'b0;
    ready = 1'b0;

    #35;
    for (int m = 0; m < 4; m++) begin
      check("reset_valid", 32'(rx_valid[m]), 32'd0);
      check("reset_data", {24'h0, rx_data[m]}, 32'd0);
      check("reset_busy", 32'(busy[m]), 32'd0);
      check("reset_flags", {29'h0, done[m], err[m], ovf[m]}, 32'd0);
      check("reset_state", 32'(state_dbg[m]), 32'(spi_pkg::ST_IDLE));
    end
    #40 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Single byte with a consumer always ready: valid for exactly one cycle.
    cur = 0;
    set_ready(1'b1);
    valid_cycles = 0;
    push_byte(8'hA5);
    run_frame(0, 8);
    check("single_byte_valid_cycles", 32'(valid_cycles), 32'd1);
    drain();
    check_counts();

    // Three bytes held back, then read out in order.
    push_byte(8'h01);
    push_byte(8'h80);
    push_byte(8'hFF);
    run_frame(0, 24);
    check("held_valid", 32'(rx_valid[0]), 32'd1);
    check("held_head", {24'h0, rx_data[0]}, 32'h01);
    repeat (10) @(negedge clk);
    check("held_head_stable", {24'h0, rx_data[0]}, 32'h01);
    drain();
    check_counts();

    // Five bytes into a four-entry FIFO: the fifth is dropped.
    for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i));
    run_frame(0, 40);
    check_counts();
    drain();

    // Frame cut after five bits.
    push_byte(8'hC3);
    run_frame(0, 5);
    tx_bits.delete();
    check("partial_no_write", 32'(rx_valid[0]), 32'd0);
    check_counts();

    // Every clock mode receives the same byte.
    for (int m = 0; m < 4; m++) begin
      cur = m;
      push_byte(8'h3C);
      run_frame(m, 8);
      check("mode_head", {24'h0, rx_data[m]}, 32'h3C);
      drain();
      check_counts();
    end

    // Reset in the middle of a byte while CS stays low.
    cur = 0;
    @(negedge clk);
    cs[0] = 1'b0;
    #100;
    for (int i = 0; i < 4; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
    shift_bits(0, 4);
    rst_n = 1'b0;
    #40 rst_n = 1'b1;
    #100;
    check("busy_after_midframe_reset", 32'(busy[0]), 32'd0);
    for (int i = 0; i < 12; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
    shift_bits(0, 12);
    #100 cs[0] = 1'b1;
    #400;
    check("midframe_reset_no_write", 32'(rx_valid[0]), 32'd0);
    check_counts();
    push_byte(8'h5A);
    run_frame(0, 8);
    check("after_reset_head", {24'h0, rx_data[0]}, 32'h5A);
    drain();
    check_counts();

    // Random frames across modes, lengths, trailing partial bits and consumer state.
    for (int f = 0; f < 8; f++) begin
      int m, nb, extra;
      m = $urandom_range(0, 3);
      cur = m;
      nb = $urandom_range(1, 6);
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      set_ready(1'($urandom_range(0, 1)));
      for (int i = 0; i < nb; i++) push_byte(8'($urandom));
      for (int i = 0; i < extra; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
      run_frame(m, nb * 8 + extra);
      tx_bits.delete();
      check_counts();
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
